ppg_sample_demux: RTL

- Receive-side counterpart of the LED/ADC sequencing in the oximeter front end.
- Watches the LED_RED/LED_IR drive phases and the shared 8-bit ADC stream.
- Captures one settled sample per LED phase and pairs RED with IR.
- Accumulates per-channel min/max over a window of pairs and reports AC (max-min) and DC ((max+min)/2) for the downstream SpO2 ratio calculation.

---
 rtl/ppg_sample_demux.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/ppg_sample_demux.sv
`default_nettype none
// ============================================================================
// Module   : ppg_sample_demux
// Purpose  : Receive-side demux for the oximeter LED/ADC sequencing. Follows
//            the LED_RED / LED_IR drive phases and captures one settled ADC
//            sample per phase. It pairs each RED sample with the next IR
//            sample. Per-channel min/max is tracked over WIN_LEN pairs, and
//            AC (max-min) and DC ((max+min)/2) are reported when a window
//            closes.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   CLK          in   system clock
//   rst_n        in   asynchronous active-low reset
//   enable       in   capture enable; low idles the block and clears the window
//   ADC[7:0]     in   shared ADC stream, one sample per CLK
//   LED_RED      in   red LED drive
//   LED_IR       in   IR LED drive
//   red_sample   out  last captured RED sample
//   ir_sample    out  last captured IR sample
//   sample_valid out  1-cycle pulse, new RED/IR pair
//   red_ac/dc    out  RED window statistics
//   ir_ac/dc     out  IR window statistics
//   stats_valid  out  1-cycle pulse, new window statistics
//   phase_err    out  1-cycle pulse, both LEDs were seen high
// ============================================================================
module ppg_sample_demux #(
  parameter int SETTLE_CYC = 2,
  parameter int WIN_LEN    = 100
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] ADC,
  input  logic       LED_RED,
  input  logic       LED_IR,
  output logic [7:0] red_sample,
  output logic [7:0] ir_sample,
  output logic       sample_valid,
  output logic [7:0] red_ac,
  output logic [7:0] red_dc,
  output logic [7:0] ir_ac,
  output logic [7:0] ir_dc,
  output logic       stats_valid,
  output logic       phase_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  // The encoding is {LED_IR, LED_RED}, so the decode is just a concatenation.
  typedef enum logic [1:0] {
    PH_DARK = 2'd0,
    PH_RED  = 2'd1,
    PH_IR   = 2'd2,
    PH_ERR  = 2'd3
  } phase_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYC);
  localparam logic [7:0] WIN_CNT     = 8'(WIN_LEN);

  phase_t     phase;
  state_t     state_q, state_d;
  phase_t     phase_q, phase_d;
  logic [3:0] settle_cnt_q, settle_cnt_d;
  logic [7:0] pair_cnt_q, pair_cnt_d;
  logic       red_pending_q, red_pending_d;
  logic [7:0] red_min_q, red_min_d, red_max_q, red_max_d;
  logic [7:0] ir_min_q, ir_min_d, ir_max_q, ir_max_d;
  logic [7:0] red_sample_q, red_sample_d, ir_sample_q, ir_sample_d;
  logic [7:0] red_ac_q, red_ac_d, red_dc_q, red_dc_d;
  logic [7:0] ir_ac_q, ir_ac_d, ir_dc_q, ir_dc_d;
  logic       sample_valid_q, sample_valid_d;
  logic       stats_valid_q, stats_valid_d;
  logic       phase_err_q, phase_err_d;

  logic       capture;
  logic       phase_change;
  logic [7:0] ir_min_new, ir_max_new;
  logic [7:0] pair_inc;

  assign phase = phase_t'({LED_IR, LED_RED});

  always_comb begin
    state_d        = state_q;
    phase_d        = phase;
    settle_cnt_d   = settle_cnt_q;
    pair_cnt_d     = pair_cnt_q;
    red_pending_d  = red_pending_q;
    red_min_d      = red_min_q;
    red_max_d      = red_max_q;
    ir_min_d       = ir_min_q;
    ir_max_d       = ir_max_q;
    red_sample_d   = red_sample_q;
    ir_sample_d    = ir_sample_q;
    red_ac_d       = red_ac_q;
    red_dc_d       = red_dc_q;
    ir_ac_d        = ir_ac_q;
    ir_dc_d        = ir_dc_q;
    sample_valid_d = 1'b0;
    stats_valid_d  = 1'b0;
    phase_err_d    = 1'b0;

    capture      = (state_q == ST_SETTLE) && (settle_cnt_q == 4'd0);
    // Coming out of IDLE, the current phase counts as freshly started.
    phase_change = (state_q == ST_IDLE) || (phase != phase_q);
    ir_min_new   = (ADC < ir_min_q) ? ADC : ir_min_q;
    ir_max_new   = (ADC > ir_max_q) ? ADC : ir_max_q;
    pair_inc     = pair_cnt_q + 8'd1;

    if (!enable) begin
      state_d       = ST_IDLE;
      pair_cnt_d    = 8'd0;
      red_pending_d = 1'b0;
      red_min_d     = 8'hFF;
      red_max_d     = 8'h00;
      ir_min_d      = 8'hFF;
      ir_max_d      = 8'h00;
    end else begin
      if (capture) begin
        state_d = ST_HOLD;
        // phase_q still names the phase being settled, even if the phase
        // changes on this very edge.
        if (phase_q == PH_RED) begin
          red_sample_d  = ADC;
          red_pending_d = 1'b1;
          red_min_d     = (ADC < red_min_q) ? ADC : red_min_q;
          red_max_d     = (ADC > red_max_q) ? ADC : red_max_q;
        end else if (phase_q == PH_IR) begin
          ir_sample_d = ADC;
          ir_min_d    = ir_min_new;
          ir_max_d    = ir_max_new;
          if (red_pending_q) begin
            sample_valid_d = 1'b1;
            red_pending_d  = 1'b0;
            if (pair_inc == WIN_CNT) begin
              // The pair's RED sample is already folded into red_min/max_q.
              red_ac_d      = red_max_q - red_min_q;
              red_dc_d      = 8'(({1'b0, red_max_q} + {1'b0, red_min_q}) >> 1);
              ir_ac_d       = ir_max_new - ir_min_new;
              ir_dc_d       = 8'(({1'b0, ir_max_new} + {1'b0, ir_min_new}) >> 1);
              stats_valid_d = 1'b1;
              pair_cnt_d    = 8'd0;
              red_min_d     = 8'hFF;
              red_max_d     = 8'h00;
              ir_min_d      = 8'hFF;
              ir_max_d      = 8'h00;
            end else begin
              pair_cnt_d = pair_inc;
            end
          end
        end
      end else if (state_q == ST_SETTLE) begin
        settle_cnt_d = settle_cnt_q - 4'd1;
      end

      // Evaluated after the capture so that a capture completes and the
      // new phase still starts its own settle on the same edge.
      if (phase_change) begin
        case (phase)
          PH_RED, PH_IR: begin
            settle_cnt_d = SETTLE_INIT;
            state_d      = ST_SETTLE;
          end
          PH_DARK: begin
            state_d = ST_HOLD;
          end
          PH_ERR: begin
            state_d       = ST_HOLD;
            phase_err_d   = 1'b1;
            red_pending_d = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      phase_q        <= PH_DARK;
      settle_cnt_q   <= 4'd0;
      pair_cnt_q     <= 8'd0;
      red_pending_q  <= 1'b0;
      red_min_q      <= 8'hFF;
      red_max_q      <= 8'h00;
      ir_min_q       <= 8'hFF;
      ir_max_q       <= 8'h00;
      red_sample_q   <= 8'd0;
      ir_sample_q    <= 8'd0;
      red_ac_q       <= 8'd0;
      red_dc_q       <= 8'd0;
      ir_ac_q        <= 8'd0;
      ir_dc_q        <= 8'd0;
      sample_valid_q <= 1'b0;
      stats_valid_q  <= 1'b0;
      phase_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      settle_cnt_q   <= settle_cnt_d;
      pair_cnt_q     <= pair_cnt_d;
      red_pending_q  <= red_pending_d;
      red_min_q      <= red_min_d;
      red_max_q      <= red_max_d;
      ir_min_q       <= ir_min_d;
      ir_max_q       <= ir_max_d;
      red_sample_q   <= red_sample_d;
      ir_sample_q    <= ir_sample_d;
      red_ac_q       <= red_ac_d;
      red_dc_q       <= red_dc_d;
      ir_ac_q        <= ir_ac_d;
      ir_dc_q        <= ir_dc_d;
      sample_valid_q <= sample_valid_d;
      stats_valid_q  <= stats_valid_d;
      phase_err_q    <= phase_err_d;
    end
  end

  assign red_sample   = red_sample_q;
  assign ir_sample    = ir_sample_q;
  assign sample_valid = sample_valid_q;
  assign red_ac       = red_ac_q;
  assign red_dc       = red_dc_q;
  assign ir_ac        = ir_ac_q;
  assign ir_dc        = ir_dc_q;
  assign stats_valid  = stats_valid_q;
  assign phase_err    = phase_err_q;

endmodule
`default_nettype wire
